ps2_scan_decoder: RTL and testbench

Consumes the byte stream from the PS/2 receive front end (8-bit word plus a one-cycle `word_ready` strobe) and turns scan-code set 2 sequences into key events. Each event carries the 8-bit key code, an extended flag (E0 prefix) and a break flag (F0 prefix). Events go into a small first-word-fall-through FIFO. Downstream logic (display, command handling, host loopback through the PS/2 sender) pops events from it at its own pace.

---
 rtl/ps2_scan_decoder.sv | 162 ++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code set 2 sequence decoder: turns received bytes into
// {ext, brk, code} key events queued in a first-word-fall-through FIFO.
module ps2_scan_decoder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic                     ck,
  input  logic                     reset,
  input  logic                     word_ready,
  input  logic [7:0]               wordIN,
  input  logic                     rd,
  input  logic                     clr_ovf,
  output logic                     key_valid,
  output logic [7:0]               key_code,
  output logic                     key_ext,
  output logic                     key_break,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = ($clog2(TIMEOUT + 1) > 18) ? $clog2(TIMEOUT + 1) : 18;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PFX, PAUSE} state_t;

  state_t          state;
  logic            ext_f;
  logic            brk_f;
  logic [2:0]      pcnt;
  logic [TW-1:0]   tcnt;

  logic            push_req;
  logic [9:0]      push_data;

  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic            do_pop;
  logic            do_push;
  logic            drop;

  // Host-protocol responses that never form key events when seen in IDLE.
  function automatic logic is_filtered(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    push_req  = 1'b0;
    push_data = {ext_f, brk_f, wordIN};
    if (word_ready) begin
      case (state)
        IDLE: begin
          if (wordIN != 8'hE0 && wordIN != 8'hF0 && wordIN != 8'hE1 && !is_filtered(wordIN)) begin
            push_req  = 1'b1;
            push_data = {2'b00, wordIN};
          end
        end
        PFX: begin
          if (wordIN != 8'hE0 && wordIN != 8'hF0) push_req = 1'b1;
        end
        PAUSE: begin
          if (pcnt == 3'd1) begin
            push_req  = 1'b1;
            push_data = {2'b10, 8'hE1};
          end
        end
        default: ;
      endcase
    end
  end

  // A byte arriving on the timeout cycle takes the word_ready branch, so it wins.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ext_f <= 1'b0;
      brk_f <= 1'b0;
      pcnt  <= '0;
      tcnt  <= '0;
    end else if (word_ready) begin
      tcnt <= '0;
      case (state)
        IDLE: begin
          case (wordIN)
            8'hE0: begin ext_f <= 1'b1; state <= PFX; end
            8'hF0: begin brk_f <= 1'b1; state <= PFX; end
            8'hE1: begin pcnt <= 3'd7; state <= PAUSE; end
            default: ;
          endcase
        end
        PFX: begin
          if (wordIN == 8'hE0) ext_f <= 1'b1;
          else if (wordIN == 8'hF0) brk_f <= 1'b1;
          else begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
            state <= IDLE;
          end
        end
        PAUSE: begin
          pcnt <= pcnt - 3'd1;
          if (pcnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tcnt == TO_LAST) begin
        state <= IDLE;
        ext_f <= 1'b0;
        brk_f <= 1'b0;
        pcnt  <= '0;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_comb begin
    do_pop  = rd && (count != '0);
    do_push = push_req && ((count != FULL_LVL) || do_pop);
    drop    = push_req && (count == FULL_LVL) && !do_pop;
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_comb begin
    key_valid = (count != '0);
    fifo_full = (count == FULL_LVL);
    level     = count;
    {key_ext, key_break, key_code} = mem[rptr];
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed scenarios plus a
// randomized byte stream compared against a timestamp-based event model.
module tb_ps2_scan_decoder;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 20;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          ck = 1'b0;
  logic          reset = 1'b0;
  logic          word_ready = 1'b0;
  logic [7:0]    wordIN = '0;
  logic          rd = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_break;
  logic          fifo_full;
  logic          overflow;
  logic [LW-1:0] level;

  int passed = 0;
  int total  = 0;

  // Reference model: prefix set, pause bytes remaining, time of last byte.
  logic [9:0] mq[$];
  bit         m_ovf = 0;
  bit         m_ext = 0, m_brk = 0, m_pfx = 0;
  int         m_pause = 0;
  int         m_last = 0;
  int         cyc = 0;

  ps2_scan_decoder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .ck(ck), .reset(reset), .word_ready(word_ready), .wordIN(wordIN),
    .rd(rd), .clr_ovf(clr_ovf), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .fifo_full(fifo_full),
    .overflow(overflow), .level(level)
  );

  always #5 ck = ~ck;

  function automatic bit filtered(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf = 0; m_ext = 0; m_brk = 0; m_pfx = 0; m_pause = 0;
  endtask

  // Drive one cycle and advance the model by the same edge.
  task automatic step(input logic v, input logic [7:0] b, input logic r, input logic c);
    bit pop, has_push, dropped;
    logic [9:0] ev;
    int t;
    word_ready = v; wordIN = b; rd = r; clr_ovf = c;
    t = cyc + 1;
    pop = r && (mq.size() > 0);
    has_push = 0; dropped = 0; ev = '0;
    if (v) begin
      if ((m_pfx || m_pause > 0) && (t - m_last > TIMEOUT)) begin
        m_pfx = 0; m_ext = 0; m_brk = 0; m_pause = 0;
      end
      if (m_pause > 0) begin
        m_pause--;
        if (m_pause == 0) begin has_push = 1; ev = {2'b10, 8'hE1}; end
      end else if (b == 8'hE0) begin m_ext = 1; m_pfx = 1; end
      else if (b == 8'hF0) begin m_brk = 1; m_pfx = 1; end
      else if (m_pfx) begin
        has_push = 1; ev = {m_ext, m_brk, b};
        m_pfx = 0; m_ext = 0; m_brk = 0;
      end
      else if (b == 8'hE1) m_pause = 7;
      else if (!filtered(b)) begin has_push = 1; ev = {2'b00, b}; end
      m_last = t;
    end
    if (pop) void'(mq.pop_front());
    if (has_push) begin
      if (mq.size() == DEPTH) begin dropped = 1; m_ovf = 1; end
      else mq.push_back(ev);
    end
    if (c && !dropped) m_ovf = 0;
    @(posedge ck); #1;
    cyc++;
    word_ready = 0; rd = 0; clr_ovf = 0;
  endtask

  task automatic send(input logic [7:0] b); step(1'b1, b, 1'b0, 1'b0); endtask
  task automatic pop1(); step(1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0); endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge ck);
    #1;
    total++; if (key_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", key_valid); else passed++;
    total++; if ({key_ext, key_break, key_code} !== 10'h000) $display("FAIL reset_head got %h want 000", {key_ext, key_break, key_code}); else passed++;
    total++; if ({fifo_full, overflow} !== 2'b00) $display("FAIL reset_flags got %b want 00", {fifo_full, overflow}); else passed++;
    total++; if (level !== '0) $display("FAIL reset_level got %0d want 0", level); else passed++;
    reset = 1;
    model_clear();
  endtask

  task automatic test_basic();
    send(8'h1C);
    total++; if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 10'h01C}) $display("FAIL basic_first got %b%h want 1 01C", key_valid, {key_ext, key_break, key_code}); else passed++;
    send(8'hF0); send(8'h1C);
    total++; if (level !== LW'(2)) $display("FAIL basic_level got %0d want 2", level); else passed++;
    total++; if ({key_ext, key_break, key_code} !== 10'h01C) $display("FAIL basic_head0 got %h want 01C", {key_ext, key_break, key_code}); else passed++;
    pop1();
    total++; if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 10'h11C}) $display("FAIL basic_head1 got %b%h want 1 11C", key_valid, {key_ext, key_break, key_code}); else passed++;
    pop1();
    total++; if ({key_valid, level} !== {1'b0, LW'(0)}) $display("FAIL basic_empty got valid=%b level=%0d want 0/0", key_valid, level); else passed++;
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h75);
    total++; if ({key_ext, key_break, key_code} !== 10'h275) $display("FAIL ext_make got %h want 275", {key_ext, key_break, key_code}); else passed++;
    pop1();
    send(8'hE0); send(8'hF0); send(8'h75);
    total++; if ({key_ext, key_break, key_code} !== 10'h375) $display("FAIL ext_break got %h want 375", {key_ext, key_break, key_code}); else passed++;
    pop1();
    send(8'hF0); send(8'hE0); send(8'h75);
    total++; if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 10'h375}) $display("FAIL ext_swapped got %b%h want 1 375", key_valid, {key_ext, key_break, key_code}); else passed++;
    pop1();
  endtask

  task automatic test_filter_pause();
    send(8'hAA); send(8'hFA);
    total++; if (key_valid !== 1'b0) $display("FAIL filter_idle got valid=%b want 0", key_valid); else passed++;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    total++; if (key_valid !== 1'b0) $display("FAIL pause_early got valid=%b want 0", key_valid); else passed++;
    send(8'h77);
    total++; if ({level, key_ext, key_break, key_code} !== {LW'(1), 10'h2E1}) $display("FAIL pause_event got level=%0d head=%h want 1/2E1", level, {key_ext, key_break, key_code}); else passed++;
    pop1();
    send(8'h1C);
    total++; if ({key_ext, key_break, key_code} !== 10'h01C) $display("FAIL pause_idle_after got %h want 01C", {key_ext, key_break, key_code}); else passed++;
    pop1();
  endtask

  task automatic test_timeout();
    send(8'hE0); idle(TIMEOUT); send(8'h1C);
    total++; if ({level, key_ext, key_break, key_code} !== {LW'(1), 10'h01C}) $display("FAIL timeout_expired got level=%0d head=%h want 1/01C", level, {key_ext, key_break, key_code}); else passed++;
    pop1();
    send(8'hE0); idle(TIMEOUT - 1); send(8'h1C);
    total++; if ({level, key_ext, key_break, key_code} !== {LW'(1), 10'h21C}) $display("FAIL timeout_edge got level=%0d head=%h want 1/21C", level, {key_ext, key_break, key_code}); else passed++;
    pop1();
    send(8'hE1); idle(TIMEOUT); send(8'h2C);
    total++; if ({key_ext, key_break, key_code} !== 10'h02C) $display("FAIL timeout_pause got %h want 02C", {key_ext, key_break, key_code}); else passed++;
    pop1();
  endtask

  task automatic test_overflow();
    logic [7:0] want [4] = '{8'h11, 8'h12, 8'h13, 8'h16};
    for (int i = 0; i < DEPTH + 2; i++) send(8'h10 + 8'(i));
    total++; if ({fifo_full, overflow, level} !== {2'b11, LW'(DEPTH)}) $display("FAIL ovf_full got full=%b ovf=%b level=%0d want 1/1/%0d", fifo_full, overflow, level, DEPTH); else passed++;
    total++; if (key_code !== 8'h10) $display("FAIL ovf_head got %h want 10", key_code); else passed++;
    step(1'b1, 8'h16, 1'b1, 1'b0);
    total++; if ({fifo_full, level, key_code} !== {1'b1, LW'(DEPTH), 8'h11}) $display("FAIL ovf_pushpop got full=%b level=%0d head=%h want 1/%0d/11", fifo_full, level, key_code, DEPTH); else passed++;
    step(1'b1, 8'h17, 1'b0, 1'b1);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_drop_beats_clr got %b want 1", overflow); else passed++;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if ({key_valid, key_code} !== {1'b1, want[i]}) $display("FAIL ovf_order%0d got %b/%h want 1/%h", i, key_valid, key_code, want[i]); else passed++;
      pop1();
    end
    total++; if (key_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", key_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    send(8'h1C); send(8'h2C); send(8'h3C); send(8'hE0);
    reset = 0;
    repeat (3) @(posedge ck);
    #1;
    total++; if ({key_valid, fifo_full, overflow, level} !== {3'b000, LW'(0)}) $display("FAIL rstmid_status got %b%b%b/%0d want 000/0", key_valid, fifo_full, overflow, level); else passed++;
    total++; if ({key_ext, key_break, key_code} !== 10'h000) $display("FAIL rstmid_head got %h want 000", {key_ext, key_break, key_code}); else passed++;
    reset = 1;
    model_clear();
    send(8'h75);
    total++; if ({key_valid, key_ext, key_break, key_code} !== {1'b1, 10'h075}) $display("FAIL rstmid_after got %b%h want 1 075", key_valid, {key_ext, key_break, key_code}); else passed++;
    pop1();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 3000; n++) begin
      logic v, r, c;
      logic [7:0] b;
      int k;
      if ($urandom_range(0, 199) == 0) idle(TIMEOUT - 1 + $urandom_range(0, 2));
      k = $urandom_range(0, 9);
      case (k)
        0, 1: b = 8'hE0;
        2:    b = 8'hF0;
        3:    b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
        4:    b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      v = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 15) == 0);
      step(v, b, r, c);
      total++;
      if (key_valid !== (mq.size() != 0) || level !== LW'(mq.size()) ||
          fifo_full !== (mq.size() == DEPTH) || overflow !== m_ovf ||
          (mq.size() != 0 && {key_ext, key_break, key_code} !== mq[0])) begin
        if (bad < 10)
          $display("FAIL random_cycle%0d got v=%b lvl=%0d full=%b ovf=%b head=%h want v=%b lvl=%0d ovf=%b head=%h",
                   n, key_valid, level, fifo_full, overflow, {key_ext, key_break, key_code},
                   mq.size() != 0, mq.size(), m_ovf, (mq.size() != 0) ? mq[0] : 10'h000);
        bad++;
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extended();
    test_filter_pause();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
